// File: rtl/prg_uploader.sv
// prg_uploader
//   Reads the BASIC program currently in RAM back out of SDRAM and streams it
//   as a length-prefixed byte stream: len[7:0], len[15:8], then len data bytes
//   starting at PRG_START_ADDR. The length comes from the 16-bit end-of-program
//   pointer held in firmware RAM at PTR_PROGND.
//
// Ports
//   sys_clock  system clock
//   reset      asynchronous active-high reset
//   ena        memory slot strobe (z80_ena cadence)
//   trigger    start request, rising-edge detected
//   abort      synchronous cancel (level)
//   ram_addr   SDRAM byte address
//   ram_rd     SDRAM read request
//   ram_din    SDRAM read data
//   out_data   stream byte
//   out_valid  out_data valid
//   out_ready  sink accepts the byte
//   busy       operation in progress (gates SDRAM mux / CPU WAIT)
//   done       one-cycle pulse on successful completion
//   error      one-cycle pulse on invalid end pointer
module prg_uploader #(
    parameter logic [24:0] PRG_START_ADDR = 25'h8241,
    parameter logic [24:0] PTR_PROGND     = 25'h81BB,
    parameter logic [15:0] MAX_LEN        = 16'h7DBF
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        ena,
    input  logic        trigger,
    input  logic        abort,
    output logic [24:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, PLO_RD, PHI_RD, CHECK, HDR_LO, HDR_HI, DAT_RD, DAT_OUT, FIN
    } state_t;

    localparam logic [15:0] START16 = PRG_START_ADDR[15:0];

    state_t      state, state_n;
    logic        trig_q;
    logic        issued, issued_n;
    logic [15:0] end_ptr, end_ptr_n;
    logic [15:0] len, len_n;
    logic [15:0] remaining, remaining_n;
    logic [24:0] ram_addr_n;
    logic        ram_rd_n, out_valid_n, busy_n, done_n, error_n;
    logic [7:0]  out_data_n;

    logic        trig_edge;
    logic        xfer;
    logic        capture;
    logic [15:0] len_calc;
    logic        bad_ptr;

    assign trig_edge = trigger & ~trig_q;
    assign xfer      = out_valid & out_ready;
    // Second ena seen with ram_rd high: the first one was the issue slot.
    assign capture   = ram_rd & ena & issued;
    assign len_calc  = end_ptr - START16;
    assign bad_ptr   = (end_ptr < START16) || (len_calc > MAX_LEN);

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            issued    <= 1'b0;
            end_ptr   <= '0;
            len       <= '0;
            remaining <= '0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            trig_q    <= trigger;
            issued    <= issued_n;
            end_ptr   <= end_ptr_n;
            len       <= len_n;
            remaining <= remaining_n;
            ram_addr  <= ram_addr_n;
            ram_rd    <= ram_rd_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        issued_n    = issued;
        end_ptr_n   = end_ptr;
        len_n       = len;
        remaining_n = remaining;
        ram_addr_n  = ram_addr;
        ram_rd_n    = ram_rd;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        error_n     = 1'b0;

        // Shared read sequencing for PLO_RD/PHI_RD/DAT_RD: raise ram_rd if a
        // previous capture dropped it, mark the issue slot on the first ena,
        // drop ram_rd on the capture edge. State-specific capture below.
        if (state == PLO_RD || state == PHI_RD || state == DAT_RD) begin
            if (!ram_rd) begin
                ram_rd_n = 1'b1;
            end else if (ena) begin
                if (!issued) begin
                    issued_n = 1'b1;
                end else begin
                    issued_n = 1'b0;
                    ram_rd_n = 1'b0;
                end
            end
        end

        unique case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_n    = PLO_RD;
                    busy_n     = 1'b1;
                    ram_addr_n = PTR_PROGND;
                    ram_rd_n   = 1'b1;
                    issued_n   = 1'b0;
                end
            end
            PLO_RD: begin
                if (capture) begin
                    end_ptr_n[7:0] = ram_din;
                    ram_addr_n     = PTR_PROGND + 25'd1;
                    state_n        = PHI_RD;
                end
            end
            PHI_RD: begin
                if (capture) begin
                    end_ptr_n[15:8] = ram_din;
                    state_n         = CHECK;
                end
            end
            CHECK: begin
                if (bad_ptr) begin
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    len_n       = len_calc;
                    out_data_n  = len_calc[7:0];
                    out_valid_n = 1'b1;
                    state_n     = HDR_LO;
                end
            end
            HDR_LO: begin
                // High header byte follows back-to-back; out_valid stays up.
                if (xfer) begin
                    out_data_n = len[15:8];
                    state_n    = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    out_valid_n = 1'b0;
                    if (len == 16'd0) begin
                        state_n = FIN;
                    end else begin
                        ram_addr_n  = PRG_START_ADDR;
                        remaining_n = len;
                        ram_rd_n    = 1'b1;
                        issued_n    = 1'b0;
                        state_n     = DAT_RD;
                    end
                end
            end
            DAT_RD: begin
                if (capture) begin
                    out_data_n  = ram_din;
                    out_valid_n = 1'b1;
                    state_n     = DAT_OUT;
                end
            end
            DAT_OUT: begin
                if (xfer) begin
                    out_valid_n = 1'b0;
                    ram_addr_n  = ram_addr + 25'd1;
                    remaining_n = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_n = FIN;
                    end else begin
                        ram_rd_n = 1'b1;
                        issued_n = 1'b0;
                        state_n  = DAT_RD;
                    end
                end
            end
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Cancel wins over everything, including a pending done/error.
        if (abort) begin
            state_n     = IDLE;
            ram_rd_n    = 1'b0;
            out_valid_n = 1'b0;
            busy_n      = 1'b0;
            issued_n    = 1'b0;
            done_n      = 1'b0;
            error_n     = 1'b0;
        end
    end

endmodule

// File: tb/tb_prg_uploader.sv
`timescale 1ns/1ps
module tb_prg_uploader;

    localparam logic [15:0] START = 16'h8241;
    localparam logic [15:0] PTR   = 16'h81BB;
    localparam logic [15:0] MAXL  = 16'h7DBF;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        ena       = 1'b0;
    logic        trigger   = 1'b0;
    logic        abort     = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_din;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        error;

    logic [7:0] mem [0:65535];
    assign ram_din = mem[ram_addr[15:0]];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always 1, 1: toggle every 3 cycles, 2: random, 3: always 0
    int n_done = 0;
    int n_err  = 0;

    logic [7:0]  exp_q  [$];
    logic [15:0] exp_rd [$];

    prg_uploader dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .ena       (ena),
        .trigger   (trigger),
        .abort     (abort),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_din   (ram_din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ena strobe: random slots, roughly one in three cycles
    initial forever begin
        @(posedge sys_clock);
        #1;
        ena = ($urandom_range(0, 2) == 0);
    end

    // sink ready pattern
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge sys_clock);
            #1;
            cyc++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((cyc / 3) % 2) == 0;
                2: out_ready = $urandom_range(0, 1) == 1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: stream scoreboard, read-address log, pulse counting
    initial begin
        logic       prev_rd;
        logic       hold_pending;
        logic [7:0] hold_data;
        logic [7:0] e;
        logic [15:0] a;
        prev_rd = 1'b0;
        hold_pending = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge sys_clock);
            if (reset) begin
                prev_rd = 1'b0;
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && out_valid)
                    chk("stable_data", {24'd0, out_data}, {24'd0, hold_data});
                hold_pending = out_valid && !out_ready && !abort;
                hold_data = out_data;
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_byte", {24'd0, out_data}, {24'd0, e});
                    end
                end
                if (ram_rd && !prev_rd) begin
                    if (exp_rd.size() == 0) begin
                        chk("extra_read", {7'd0, ram_addr}, 32'hFFFF_FFFF);
                    end else begin
                        a = exp_rd.pop_front();
                        chk("read_addr", {7'd0, ram_addr}, {16'd0, a});
                    end
                end
                prev_rd = ram_rd;
                if (done) n_done++;
                if (error) n_err++;
                if (done || error)
                    chk("done_error_excl", {31'd0, done & error}, 32'd0);
            end
        end
    end

    // Reference model: the expected reads and stream follow directly from
    // the pointer bytes and the program bytes in memory.
    task automatic expect_op();
        logic [15:0] endp;
        logic [15:0] n;
        endp = {mem[PTR + 16'd1], mem[PTR]};
        exp_rd.push_back(PTR);
        exp_rd.push_back(PTR + 16'd1);
        if (endp < START || (endp - START) > MAXL) return;
        n = endp - START;
        exp_q.push_back(n[7:0]);
        exp_q.push_back(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[START + 16'(i)]);
            exp_rd.push_back(START + 16'(i));
        end
    endtask

    function automatic bit model_is_error();
        logic [15:0] endp;
        endp = {mem[PTR + 16'd1], mem[PTR]};
        return (endp < START) || ((endp - START) > MAXL);
    endfunction

    task automatic load_prog(input logic [15:0] endp, input int n);
        mem[PTR]         = endp[7:0];
        mem[PTR + 16'd1] = endp[15:8];
        for (int i = 0; i < n; i++) mem[START + 16'(i)] = 8'($urandom);
    endtask

    task automatic pulse_trigger(input bit check_busy);
        @(posedge sys_clock);
        #1 trigger = 1'b1;
        @(posedge sys_clock);
        #1 trigger = 1'b0;
        if (check_busy) chk("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("timeout_busy", 32'd1, 32'd0);
            #1 abort = 1'b1;
            @(posedge sys_clock);
            #1 abort = 1'b0;
        end
    endtask

    task automatic finish_op(input string tag, input int d0, input int e0, input bit is_err);
        repeat (2) @(negedge sys_clock);
        chk({tag, "_done"}, n_done - d0, is_err ? 0 : 1);
        chk({tag, "_error"}, n_err - e0, is_err ? 1 : 0);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, exp_rd.size(), 0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        exp_rd.delete();
    endtask

    task automatic run_op(input string tag);
        int d0, e0;
        bit is_err;
        d0 = n_done;
        e0 = n_err;
        is_err = model_is_error();
        expect_op();
        pulse_trigger(1'b1);
        wait_idle(4000);
        finish_op(tag, d0, e0, is_err);
    endtask

    initial begin
        int d0, e0;
        bit ok;

        // reset state
        repeat (3) @(negedge sys_clock);
        chk("rst_ram_addr", {7'd0, ram_addr}, 32'd0);
        chk("rst_ram_rd", {31'd0, ram_rd}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        @(posedge sys_clock);
        #1 reset = 1'b0;

        // 3-byte program, sink always ready
        ready_mode = 0;
        mem[PTR] = 8'h44; mem[PTR + 16'd1] = 8'h82;
        mem[START] = 8'hAA; mem[START + 16'd1] = 8'hBB; mem[START + 16'd2] = 8'hCC;
        run_op("prog3");

        // empty program
        load_prog(16'h8241, 0);
        run_op("empty");

        // end below start, and end of zero
        load_prog(16'h8000, 0);
        run_op("below");
        load_prog(16'h0000, 0);
        run_op("zero");

        // same 3-byte program with back-pressure
        mem[PTR] = 8'h44; mem[PTR + 16'd1] = 8'h82;
        mem[START] = 8'hAA; mem[START + 16'd1] = 8'hBB; mem[START + 16'd2] = 8'hCC;
        ready_mode = 1;
        run_op("toggle");

        // second trigger edge mid-transfer is ignored
        ready_mode = 0;
        load_prog(START + 16'd8, 8);
        d0 = n_done; e0 = n_err;
        expect_op();
        pulse_trigger(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clock);
            if (exp_q.size() <= 6) begin ok = 1'b1; break; end
        end
        chk("retrig_reached", {31'd0, ok}, 32'd1);
        pulse_trigger(1'b0);
        wait_idle(4000);
        repeat (10) @(negedge sys_clock);
        chk("retrig_no_restart", {31'd0, busy}, 32'd0);
        finish_op("retrig", d0, e0, 1'b0);

        // abort while fetching the 2nd data byte
        load_prog(START + 16'd4, 4);
        d0 = n_done; e0 = n_err;
        expect_op();
        pulse_trigger(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clock);
            if (ram_rd && ram_addr == {9'd0, START + 16'd1}) begin ok = 1'b1; break; end
        end
        chk("abort_reached", {31'd0, ok}, 32'd1);
        #1 abort = 1'b1;
        @(posedge sys_clock);
        #1 abort = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_rd", {31'd0, ram_rd}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge sys_clock);
        chk("abort_busy_stays", {31'd0, busy}, 32'd0);
        chk("abort_bytes_dropped", exp_q.size(), 3);
        chk("abort_reads_dropped", exp_rd.size(), 2);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_no_error", n_err - e0, 0);
        exp_q.delete();
        exp_rd.delete();

        // asynchronous reset during a data read, then a clean restart
        load_prog(START + 16'd6, 6);
        expect_op();
        pulse_trigger(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clock);
            if (ram_rd && ram_addr[15:0] >= START) begin ok = 1'b1; break; end
        end
        chk("rst_mid_reached", {31'd0, ok}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_rd", {31'd0, ram_rd}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_addr", {7'd0, ram_addr}, 32'd0);
        exp_q.delete();
        exp_rd.delete();
        repeat (3) @(posedge sys_clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge sys_clock);
        chk("rst_mid_no_autostart", {31'd0, busy}, 32'd0);
        run_op("after_rst");

        // randomized programs and sink behaviour
        for (int t = 0; t < 8; t++) begin
            int n;
            ready_mode = $urandom_range(0, 2);
            n = $urandom_range(0, 20);
            if (t == 5) load_prog(16'($urandom_range(0, 16'h8240)), 0);
            else        load_prog(START + 16'(n), n);
            run_op("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
